// File: rtl/mips_int_ctrl.sv
// rtl/mips_int_ctrl.sv - interrupt controller: edge-latched requests, fixed priority, safe-point redirect, ERET return
module mips_int_ctrl #(
   parameter int          NSRC        = 4,
   parameter logic [31:0] VECTOR_BASE = 32'h0000_0010
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_in,
   input  logic [NSRC-1:0] irq_mask,
   input  logic            safe_valid,
   input  logic [31:0]     safe_pc,
   input  logic            eret,
   output logic            redirect,
   output logic [31:0]     redirect_pc,
   output logic [31:0]     epc,
   output logic [2:0]      cause,
   output logic            in_handler,
   output logic [NSRC-1:0] pending
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ENTER,
      S_HANDLER,
      S_RETURN
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [NSRC-1:0] s1;
   logic [NSRC-1:0] s2;
   logic [NSRC-1:0] s3;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] clear;
   logic [NSRC-1:0] pending_nx;
   logic [2:0]      winner;
   logic            take;

   // s1/s2 resolve metastability, s3 gives the previous level for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= irq_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise     = s2 & ~s3;
   assign eligible = pending & irq_mask;

   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = 3'(i);
         end
      end
   end

   assign take = (state == S_WAIT) && (eligible != '0) && safe_valid;

   always_comb begin
      clear = '0;
      for (int i = 0; i < NSRC; i++) begin
         clear[i] = take && (winner == 3'(i));
      end
   end

   // a new rising edge in the same cycle as the take must not be lost
   assign pending_nx = (pending & ~clear) | rise;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pending <= '0;
         epc     <= '0;
         cause   <= '0;
      end else begin
         state   <= state_nx;
         pending <= pending_nx;
         if (take) begin
            epc   <= safe_pc;
            cause <= winner;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (eligible != '0) begin
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (eligible == '0) begin
               state_nx = S_IDLE;
            end else if (safe_valid) begin
               state_nx = S_ENTER;
            end
         end
         S_ENTER: begin
            state_nx = S_HANDLER;
         end
         S_HANDLER: begin
            if (eret) begin
               state_nx = S_RETURN;
            end
         end
         S_RETURN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      redirect_pc = '0;
      case (state)
         S_ENTER:  redirect_pc = VECTOR_BASE + {25'd0, cause, 4'b0000};
         S_RETURN: redirect_pc = epc;
         default:  redirect_pc = '0;
      endcase
   end

   assign redirect   = (state == S_ENTER) || (state == S_RETURN);
   assign in_handler = (state == S_ENTER) || (state == S_HANDLER) || (state == S_RETURN);

endmodule

// File: tb/tb_mips_int_ctrl.sv
// tb/tb_mips_int_ctrl.sv - randomized and directed scoreboard bench for mips_int_ctrl
module tb_mips_int_ctrl;

   localparam int          NSRC = 4;
   localparam logic [31:0] VB   = 32'h0000_0010;
   localparam int M_IDLE = 0, M_WAIT = 1, M_ENTER = 2, M_HANDLER = 3, M_RETURN = 4;

   typedef struct {
      int          cyc;
      logic [31:0] pc;
      logic [31:0] epc;
      logic [2:0]  cause;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] irq_in;
   logic [NSRC-1:0] irq_mask;
   logic            safe_valid;
   logic [31:0]     safe_pc;
   logic            eret;
   logic            redirect;
   logic [31:0]     redirect_pc;
   logic [31:0]     epc;
   logic [2:0]      cause;
   logic            in_handler;
   logic [NSRC-1:0] pending;

   int n_chk  = 0;
   int n_pass = 0;

   int              ncyc = 0;
   logic [NSRC-1:0] hist [int];
   logic [NSRC-1:0] m_pend;
   int              m_mode;
   logic [31:0]     m_epc;
   logic [2:0]      m_cause;
   exp_t            exp_q [$];

   mips_int_ctrl #(.NSRC(NSRC), .VECTOR_BASE(VB)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
      .safe_valid(safe_valid), .safe_pc(safe_pc), .eret(eret),
      .redirect(redirect), .redirect_pc(redirect_pc), .epc(epc),
      .cause(cause), .in_handler(in_handler), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   function automatic logic [NSRC-1:0] samp(input int k);
      if (hist.exists(k)) return hist[k];
      return '0;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_mode  = M_IDLE;
      m_epc   = '0;
      m_cause = '0;
      hist.delete();
      exp_q.delete();
   endtask

   // Reference: a request counts as risen two edges after it is first sampled high
   // after a low sample; service and return follow the entry/return rules as events.
   task automatic model_edge();
      logic [NSRC-1:0] rise, elig, clr;
      int w;
      exp_t e;
      ncyc++;
      if (rst !== 1'b1) begin
         model_reset();
         return;
      end
      hist[ncyc] = irq_in;
      rise = samp(ncyc - 2) & ~samp(ncyc - 3);
      elig = m_pend & irq_mask;
      clr  = '0;
      case (m_mode)
         M_IDLE:    if (elig != 0) m_mode = M_WAIT;
         M_WAIT: begin
            if (elig == 0) m_mode = M_IDLE;
            else if (safe_valid) begin
               w = -1;
               for (int i = 0; i < NSRC; i++) if (elig[i] && w < 0) w = i;
               m_epc   = safe_pc;
               m_cause = 3'(w);
               clr[w]  = 1'b1;
               m_mode  = M_ENTER;
               e.cyc = ncyc; e.pc = VB + 32'(16 * w); e.epc = safe_pc; e.cause = 3'(w);
               exp_q.push_back(e);
            end
         end
         M_ENTER:   m_mode = M_HANDLER;
         M_HANDLER: begin
            if (eret) begin
               m_mode = M_RETURN;
               e.cyc = ncyc; e.pc = m_epc; e.epc = m_epc; e.cause = m_cause;
               exp_q.push_back(e);
            end
         end
         default:   m_mode = M_IDLE;
      endcase
      m_pend = (m_pend & ~clr) | rise;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         check("in_handler", 32'(in_handler),
               32'(m_mode == M_ENTER || m_mode == M_HANDLER || m_mode == M_RETURN));
         check("pending", 32'(pending), 32'(m_pend));
         if (redirect === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_redirect", 32'(redirect), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("redirect_cycle", 32'(ncyc), 32'(e.cyc));
               check("redirect_pc", redirect_pc, e.pc);
               check("epc", epc, e.epc);
               check("cause", 32'(cause), 32'(e.cause));
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= ncyc) begin
            e = exp_q.pop_front();
            check("missed_redirect", 32'(redirect), 32'd1);
         end
      end
   end

   task automatic step(input logic [NSRC-1:0] irq, input logic [NSRC-1:0] msk,
                       input logic sv, input logic [31:0] spc, input logic er);
      irq_in = irq; irq_mask = msk; safe_valid = sv; safe_pc = spc; eret = er;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic run_until(input logic [NSRC-1:0] irq, input logic [NSRC-1:0] msk,
                            input logic sv, input logic [31:0] spc, output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step(irq, msk, sv, spc, 1'b0);
         if (redirect === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic do_eret(input string name, input logic [31:0] ret_pc);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      step('0, '1, 1'b0, 32'h0, 1'b1);
      check({name, "_ret_redirect"}, 32'(redirect), 32'd1);
      check({name, "_ret_pc"}, redirect_pc, ret_pc);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_redirect"}, 32'(redirect), 32'd0);
      check({name, "_redirect_pc"}, redirect_pc, 32'd0);
      check({name, "_epc"}, epc, 32'd0);
      check({name, "_cause"}, 32'(cause), 32'd0);
      check({name, "_in_handler"}, 32'(in_handler), 32'd0);
      check({name, "_pending"}, 32'(pending), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1);
   end

   initial begin
      int n, cnt;
      logic [NSRC-1:0] r_irq, r_msk;

      rst = 1'b0; irq_in = '0; irq_mask = '0; safe_valid = 1'b0; safe_pc = '0; eret = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      step('0, '1, 1'b0, 32'h0, 1'b0);

      // basic entry and return
      step(4'b0001, '1, 1'b1, 32'h40, 1'b0);
      step(4'b0001, '1, 1'b1, 32'h40, 1'b0);
      run_until('0, '1, 1'b1, 32'h40, n);
      check("basic_latency", 32'(2 + n), 32'd5);
      check("basic_pc", redirect_pc, 32'h10);
      check("basic_epc", epc, 32'h40);
      check("basic_cause", 32'(cause), 32'd0);
      do_eret("basic", 32'h40);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      check("basic_in_handler_off", 32'(in_handler), 32'd0);

      // simultaneous sources 1 and 3
      step(4'b1010, '1, 1'b1, 32'h200, 1'b0);
      step(4'b1010, '1, 1'b1, 32'h200, 1'b0);
      run_until('0, '1, 1'b1, 32'h200, n);
      check("prio_cause", 32'(cause), 32'd1);
      check("prio_pc", redirect_pc, 32'h20);
      check("prio_pending", 32'(pending), 32'b1000);
      do_eret("prio", 32'h200);
      run_until('0, '1, 1'b1, 32'h300, n);
      check("prio2_cause", 32'(cause), 32'd3);
      check("prio2_pc", redirect_pc, 32'h40);
      do_eret("prio2", 32'h300);
      step('0, '1, 1'b0, 32'h0, 1'b0);

      // masked request is held, then serviced once unmasked
      step(4'b0001, 4'b1110, 1'b1, 32'h80, 1'b0);
      step(4'b0001, 4'b1110, 1'b1, 32'h80, 1'b0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step('0, 4'b1110, 1'b1, 32'h80, 1'b0);
         if (redirect === 1'b1) cnt++;
      end
      check("mask_no_redirect", 32'(cnt), 32'd0);
      check("mask_pending", 32'(pending), 32'b0001);
      run_until('0, '1, 1'b1, 32'h80, n);
      check("unmask_cause", 32'(cause), 32'd0);
      check("unmask_pc", redirect_pc, 32'h10);
      do_eret("unmask", 32'h80);
      step('0, '1, 1'b0, 32'h0, 1'b0);

      // safe point withheld for 5 cycles in WAIT
      step(4'b0001, '1, 1'b0, 32'h0, 1'b0);
      step(4'b0001, '1, 1'b0, 32'h0, 1'b0);
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         step('0, '1, 1'b0, 32'hdead_beef, 1'b0);
         if (redirect === 1'b1) cnt++;
      end
      check("stall_no_redirect", 32'(cnt), 32'd0);
      run_until('0, '1, 1'b1, 32'h100, n);
      check("stall_latency", 32'(n), 32'd1);
      check("stall_epc", epc, 32'h100);
      do_eret("stall", 32'h100);
      step('0, '1, 1'b0, 32'h0, 1'b0);

      // asynchronous reset while in the handler
      step(4'b0010, '1, 1'b1, 32'h44, 1'b0);
      step(4'b0010, '1, 1'b1, 32'h44, 1'b0);
      run_until('0, '1, 1'b1, 32'h44, n);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      check("midrst_in_handler_before", 32'(in_handler), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check_all_zero("midrst");
      step('0, '1, 1'b0, 32'h0, 1'b0);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      step('0, '1, 1'b0, 32'h0, 1'b1);
      check("midrst_eret_ignored", 32'(redirect), 32'd0);
      step('0, '1, 1'b0, 32'h0, 1'b0);

      // source 2 rises again on the edge it is taken
      step(4'b0100, '1, 1'b0, 32'h0, 1'b0);
      step(4'b0100, '1, 1'b0, 32'h0, 1'b0);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      step('0, '1, 1'b0, 32'h0, 1'b0);
      step(4'b0100, '1, 1'b0, 32'h0, 1'b0);
      step(4'b0100, '1, 1'b0, 32'h0, 1'b0);
      step('0, '1, 1'b1, 32'h600, 1'b0);
      check("repend_redirect", 32'(redirect), 32'd1);
      check("repend_cause", 32'(cause), 32'd2);
      check("repend_pending", 32'(pending), 32'b0100);
      do_eret("repend", 32'h600);
      run_until('0, '1, 1'b1, 32'h700, n);
      check("repend2_cause", 32'(cause), 32'd2);
      check("repend2_pc", redirect_pc, 32'h30);
      do_eret("repend2", 32'h700);

      // randomized traffic against the reference model
      r_irq = '0;
      r_msk = '1;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
         if ($urandom_range(0, 49) == 0) r_msk = NSRC'($urandom);
         step(r_irq, r_msk, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 4) == 0);
      end

      for (int c = 0; c < 80; c++) step('0, '1, 1'b1, 32'h1234, 1'b1);
      check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
      check("drain_pending", 32'(pending), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
